// File: rtl/cgra_tcdm_arbiter.sv
// Round-robin arbiter sharing one TCDM port among N_REQ CGRA columns, with a response-order FIFO.
// Optional stall counter output enabled by macro CGRA_TCDM_ARB_PERF_CNT_EN.
module cgra_tcdm_arbiter #(
  parameter int unsigned N_REQ           = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [N_REQ-1:0]                 req_i,
  input  logic [N_REQ*ADDR_WIDTH-1:0]      add_i,
  input  logic [N_REQ-1:0]                 wen_i,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]    be_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]      wdata_i,
  output logic [N_REQ-1:0]                 gnt_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic [N_REQ-1:0]                 rvalid_o,
  output logic                             bus_req_o,
  output logic [ADDR_WIDTH-1:0]            bus_add_o,
  output logic                             bus_wen_o,
  output logic [DATA_WIDTH/8-1:0]          bus_be_o,
  output logic [DATA_WIDTH-1:0]            bus_wdata_o,
  input  logic                             bus_gnt_i,
  input  logic                             bus_rvalid_i,
  input  logic [DATA_WIDTH-1:0]            bus_rdata_i,
  output logic                             err_o
`ifdef CGRA_TCDM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]                      stall_cnt_o
`endif
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned FP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [FP_W-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] mem_q [MAX_OUTSTANDING];

  logic [IDX_W-1:0] rr_idx, winner, head;
  logic             fifo_full, hs, pop;

  function automatic logic [FP_W-1:0] fp_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Round-robin search: ptr_q has highest priority, then upward with wrap.
  always_comb begin
    logic found;
    int   k;
    found  = 1'b0;
    rr_idx = '0;
    k      = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      k = int'(ptr_q) + i;
      if (k >= int'(N_REQ)) k = k - int'(N_REQ);
      if (!found && req_i[IDX_W'(k)]) begin
        found  = 1'b1;
        rr_idx = IDX_W'(k);
      end
    end
  end

  assign winner    = lock_q ? lock_idx_q : rr_idx;
  assign fifo_full = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign bus_req_o = !rst_i && (|req_i) && !fifo_full;
  assign hs        = bus_req_o && bus_gnt_i;
  assign gnt_o     = hs ? (N_REQ'(1) << winner) : '0;

  assign bus_add_o   = add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus_wen_o   = wen_i[winner];
  assign bus_be_o    = be_i[winner*BE_W +: BE_W];
  assign bus_wdata_o = wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];

  assign head     = mem_q[rd_q];
  assign pop      = !rst_i && bus_rvalid_i && (cnt_q != '0);
  assign rvalid_o = pop ? (N_REQ'(1) << head) : '0;
  assign rdata_o  = pop ? bus_rdata_i : '0;
  assign err_o    = err_q;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if (hs) begin
      ptr_d  = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
      lock_d = 1'b0;
      wr_d   = fp_inc(wr_q);
    end else if (bus_req_o) begin
      // Stalled request keeps its column until the bus accepts it.
      lock_d     = 1'b1;
      lock_idx_d = winner;
    end
    if (pop) rd_d = fp_inc(rd_q);
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (bus_rvalid_i && (cnt_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) mem_q[wr_q] <= winner;
  end

`ifdef CGRA_TCDM_ARB_PERF_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((|req_i) && (gnt_o == '0) && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_cgra_tcdm_arbiter.sv
// Directed table-driven bench for cgra_tcdm_arbiter (N_REQ=4, MAX_OUTSTANDING=4).
module tb_cgra_tcdm_arbiter;
  localparam int N = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req, wen, gnt, rvalid;
  logic [N*AW-1:0] add;
  logic [N*DW/8-1:0] be;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, bus_rdata, bus_wdata;
  logic          bus_req, bus_wen, bus_gnt, bus_rvalid, err;
  logic [AW-1:0] bus_add;
  logic [DW/8-1:0] bus_be;
`ifdef CGRA_TCDM_ARB_PERF_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  cgra_tcdm_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rdata_o(rdata), .rvalid_o(rvalid),
    .bus_req_o(bus_req), .bus_add_o(bus_add), .bus_wen_o(bus_wen), .bus_be_o(bus_be),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .err_o(err)
`ifdef CGRA_TCDM_ARB_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        e_breq;
    int          e_col;
    logic [3:0]  e_gnt;
    logic [3:0]  e_rv;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(logic [3:0] r, logic g, logic v, logic [31:0] d, logic eb,
                              int ec, logic [3:0] eg, logic [3:0] ev, logic [31:0] ed, logic ee);
    vec_t t;
    t.req = r; t.gnt = g; t.rv = v; t.rdata = d; t.e_breq = eb; t.e_col = ec;
    t.e_gnt = eg; t.e_rv = ev; t.e_rdata = ed; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] col_addr(int k);
    return 32'h1000_0000 + 32'(k) * 32'h10;
  endfunction

  // Drive at the falling edge, sample 1 ns later, well before the next rising edge.
  task automatic drive(input logic [3:0] r, input logic g, input logic v, input logic [31:0] d);
    @(negedge clk);
    req = r; bus_gnt = g; bus_rvalid = v; bus_rdata = d;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    wen = 4'b1010;
    for (int k = 0; k < N; k++) begin
      add[k*AW +: AW]       = col_addr(k);
      be[k*4 +: 4]          = 4'b0001 << k;
      wdata[k*DW +: DW]     = 32'hCAFE_0000 + 32'(k);
    end

    // Outputs forced quiet while in reset, whatever the inputs do.
    @(negedge clk);
    req = 4'b1111; bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hDEAD;
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    @(negedge clk);
    #1;
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0; req = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0;

    // {req, gnt, rv, rdata, e_breq, e_col, e_gnt, e_rv, e_rdata, e_err}
    tbl.push_back(mk(4'b0000,0,0,32'h0 ,0,0,4'b0000,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b1111,1,0,32'h0 ,1,0,4'b0001,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b1111,1,0,32'h0 ,1,1,4'b0010,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b1111,1,0,32'h0 ,1,2,4'b0100,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b1111,1,0,32'h0 ,1,3,4'b1000,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b1111,1,1,32'h55,0,0,4'b0000,4'b0001,32'h55,0));
    tbl.push_back(mk(4'b1111,1,0,32'h0 ,1,0,4'b0001,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b0000,0,1,32'h11,0,0,4'b0000,4'b0010,32'h11,0));
    tbl.push_back(mk(4'b0000,0,1,32'h22,0,0,4'b0000,4'b0100,32'h22,0));
    tbl.push_back(mk(4'b0000,0,1,32'h33,0,0,4'b0000,4'b1000,32'h33,0));
    tbl.push_back(mk(4'b0000,0,1,32'h44,0,0,4'b0000,4'b0001,32'h44,0));
    tbl.push_back(mk(4'b0000,0,1,32'h66,0,0,4'b0000,4'b0000,32'h0 ,0));
    tbl.push_back(mk(4'b0000,0,0,32'h0 ,0,0,4'b0000,4'b0000,32'h0 ,1));
    tbl.push_back(mk(4'b1000,1,0,32'h0 ,1,3,4'b1000,4'b0000,32'h0 ,1));
    tbl.push_back(mk(4'b0010,1,0,32'h0 ,1,1,4'b0010,4'b0000,32'h0 ,1));
    tbl.push_back(mk(4'b0100,1,0,32'h0 ,1,2,4'b0100,4'b0000,32'h0 ,1));
    tbl.push_back(mk(4'b0001,1,1,32'hA ,1,0,4'b0001,4'b1000,32'hA ,1));
    tbl.push_back(mk(4'b0000,0,1,32'hB ,0,0,4'b0000,4'b0010,32'hB ,1));
    tbl.push_back(mk(4'b0000,0,1,32'hC ,0,0,4'b0000,4'b0100,32'hC ,1));
    tbl.push_back(mk(4'b0000,0,1,32'hD ,0,0,4'b0000,4'b0001,32'hD ,1));
    tbl.push_back(mk(4'b0000,0,0,32'h0 ,0,0,4'b0000,4'b0000,32'h0 ,1));

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("v%0d_bus_req", i), 64'(bus_req), 64'(tbl[i].e_breq));
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(tbl[i].e_gnt));
      chk($sformatf("v%0d_rvalid", i), 64'(rvalid), 64'(tbl[i].e_rv));
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(tbl[i].e_rdata));
      chk($sformatf("v%0d_err", i), 64'(err), 64'(tbl[i].e_err));
      if (tbl[i].e_breq) begin
        chk($sformatf("v%0d_add", i), 64'(bus_add), 64'(col_addr(tbl[i].e_col)));
        chk($sformatf("v%0d_wen", i), 64'(bus_wen), 64'(wen[tbl[i].e_col]));
        chk($sformatf("v%0d_be", i), 64'(bus_be), 64'(4'b0001 << tbl[i].e_col));
        chk($sformatf("v%0d_wdata", i), 64'(bus_wdata), 64'(32'hCAFE_0000 + 32'(tbl[i].e_col)));
      end
    end

    // Reset clears the sticky error.
    do_reset();
    #1;
    chk("err_cleared", 64'(err), 64'd0);

    // Stalled column 2 keeps the bus while column 0 (higher priority) shows up.
    drive(4'b0100, 1'b0, 1'b0, 32'h0);
    chk("lock_c0_add", 64'(bus_add), 64'(col_addr(2)));
    chk("lock_c0_gnt", 64'(gnt), 64'd0);
    drive(4'b0101, 1'b0, 1'b0, 32'h0);
    chk("lock_c1_add", 64'(bus_add), 64'(col_addr(2)));
    drive(4'b0101, 1'b0, 1'b0, 32'h0);
    chk("lock_c2_add", 64'(bus_add), 64'(col_addr(2)));
    drive(4'b0101, 1'b1, 1'b0, 32'h0);
    chk("lock_c3_gnt", 64'(gnt), 64'b0100);
    chk("lock_c3_add", 64'(bus_add), 64'(col_addr(2)));
    drive(4'b0001, 1'b1, 1'b0, 32'h0);
    chk("lock_c4_gnt", 64'(gnt), 64'b0001);
    chk("lock_c4_add", 64'(bus_add), 64'(col_addr(0)));

    // Error on an unexpected response stays set until reset.
    do_reset();
    drive(4'b0000, 1'b0, 1'b1, 32'h77);
    chk("err_rv", 64'(rvalid), 64'd0);
    chk("err_rdata", 64'(rdata), 64'd0);
    drive(4'b0000, 1'b0, 1'b0, 32'h0);
    chk("err_set", 64'(err), 64'd1);
    repeat (3) drive(4'b0000, 1'b0, 1'b0, 32'h0);
    chk("err_sticky", 64'(err), 64'd1);
    do_reset();
    #1;
    chk("err_reset", 64'(err), 64'd0);

`ifdef CGRA_TCDM_ARB_PERF_CNT_EN
    for (int c = 0; c < 10; c++) drive(4'b0001, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    req = '0;
    #1;
    chk("stall_10", 64'(stall_cnt), 64'd10);
    do_reset();
    #1;
    chk("stall_reset", 64'(stall_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
